// File: rtl/fdam_arb_pkg.sv
// Shared definitions for the FDAM read-request arbiter: default widths and
// the round-robin pick helper used by fdam_rr_arbiter.
package fdam_arb_pkg;

   localparam int unsigned ARB_DATA_WIDTH = 64;
   localparam int unsigned ARB_TAG_WIDTH  = 16;

   // Upper bound on requesters the pick helper can scan.
   localparam int unsigned RR_MAX_REQ = 32;
   localparam int unsigned RR_IDX_W   = $clog2(RR_MAX_REQ);

   typedef struct packed {
      logic                found;
      logic [RR_IDX_W-1:0] idx;
   } rr_pick_t;

   // First set bit of valid_vec scanning ptr, ptr+1, ... modulo num_req.
   function automatic rr_pick_t rr_pick(
      input logic [RR_MAX_REQ-1:0] valid_vec,
      input logic [RR_IDX_W-1:0]   ptr,
      input int unsigned           num_req
   );
      rr_pick_t    res;
      int unsigned j;
      res = '0;
      for (int unsigned k = 0; k < RR_MAX_REQ; k++) begin
         if (k < num_req) begin
            j = 32'(ptr) + k;
            if (j >= num_req) begin
               j = j - num_req;
            end
            if (!res.found && valid_vec[j[RR_IDX_W-1:0]]) begin
               res.found = 1'b1;
               res.idx   = j[RR_IDX_W-1:0];
            end
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/fdam_rr_arbiter.sv
// Round-robin grant over NUM_REQ requesters (NUM_REQ <= 32).
// The pointer moves past the winner only when a grant is actually taken.
module fdam_rr_arbiter
   import fdam_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req_i,
   input  logic               advance_i,
   output logic [NUM_REQ-1:0] grant_o,
   output logic [IDX_W-1:0]   grant_idx_o,
   output logic               grant_valid_o
);

   logic [IDX_W-1:0] rr_ptr_q;
   logic [IDX_W-1:0] rr_ptr_d;
   rr_pick_t         pick;
   logic             grant_valid;
   logic [IDX_W-1:0] grant_idx;

   // Winner search and next pointer value.
   always_comb begin
      pick        = rr_pick(RR_MAX_REQ'(req_i), RR_IDX_W'(rr_ptr_q), NUM_REQ);
      grant_valid = advance_i && !rst && pick.found;
      grant_idx   = IDX_W'(pick.idx);
      grant_o     = '0;
      rr_ptr_d    = rr_ptr_q;
      if (grant_valid) begin
         grant_o[grant_idx] = 1'b1;
         if (32'(grant_idx) == NUM_REQ - 1) begin
            rr_ptr_d = '0;
         end else begin
            rr_ptr_d = grant_idx + IDX_W'(1);
         end
      end
   end

   assign grant_idx_o   = grant_idx;
   assign grant_valid_o = grant_valid;

   // Round-robin pointer register.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
      end
   end

endmodule

// File: rtl/fdam_read_request_arbiter.sv
// Shares one host read-request channel among NUM_REQ queue controllers.
// Round-robin arbitration into a one-entry output slot, with a per-requester
// cap on in-flight reads (decremented by response beats tagged with the
// requester's queue id).
// Optional build macro FDAM_RD_ARB_STATS_EN adds issued_count/stall_count.
module fdam_read_request_arbiter
   import fdam_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ         = 4,
   parameter int unsigned DATA_WIDTH      = ARB_DATA_WIDTH,
   parameter int unsigned TAG_WIDTH       = ARB_TAG_WIDTH,
   parameter int unsigned QUEUE_BASE      = 0,
   parameter int unsigned MAX_OUTSTANDING = 8,
   parameter int unsigned CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          available_read,
   output logic                          request_read,
   output logic [DATA_WIDTH-1:0]         request_data,
   input  logic                          read_data_valid,
   input  logic [TAG_WIDTH-1:0]          read_queue_id,
   output logic                          busy
`ifdef FDAM_RD_ARB_STATS_EN
   ,
   output logic [NUM_REQ*32-1:0]         issued_count,
   output logic [31:0]                   stall_count
`endif
);

   localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic                  slot_valid_q;
   logic [DATA_WIDTH-1:0] slot_data_q;
   logic                  request_read_q;
   logic [DATA_WIDTH-1:0] request_data_q;
   logic                  busy_q;
   logic [CNT_WIDTH-1:0]  cnt_q [NUM_REQ];
   logic [CNT_WIDTH-1:0]  cnt_d [NUM_REQ];

   logic                  issue;
   logic                  arb_en;
   logic [NUM_REQ-1:0]    eligible;
   logic [NUM_REQ-1:0]    grant;
   logic [IDX_W-1:0]      grant_idx;
   logic                  grant_valid;
   logic [NUM_REQ-1:0]    cnt_inc;
   logic [NUM_REQ-1:0]    cnt_dec;
   logic                  cnt_nz;

   // Issue/arbitration window and per-requester eligibility.
   always_comb begin
      issue  = slot_valid_q && available_read;
      arb_en = !rst && (!slot_valid_q || issue);
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         eligible[i] = req_valid[i] && (cnt_q[i] < CNT_WIDTH'(MAX_OUTSTANDING));
      end
   end

   fdam_rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_arbiter (
      .clk           (clk),
      .rst           (rst),
      .req_i         (eligible),
      .advance_i     (arb_en),
      .grant_o       (grant),
      .grant_idx_o   (grant_idx),
      .grant_valid_o (grant_valid)
   );

   assign req_ready = grant;

   // Output slot and the registered host-side request.
   always_ff @(posedge clk) begin
      if (rst) begin
         slot_valid_q   <= 1'b0;
         slot_data_q    <= '0;
         request_read_q <= 1'b0;
         request_data_q <= '0;
      end else begin
         request_read_q <= issue;
         if (issue) begin
            request_data_q <= slot_data_q;
         end
         if (grant_valid) begin
            slot_valid_q <= 1'b1;
            slot_data_q  <= req_data[32'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
         end else if (issue) begin
            slot_valid_q <= 1'b0;
         end
      end
   end

   // Accept/response events per requester; responses against an empty counter are dropped.
   always_comb begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         cnt_inc[i] = grant[i];
         cnt_dec[i] = read_data_valid
                      && (read_queue_id == TAG_WIDTH'(QUEUE_BASE + i))
                      && (cnt_q[i] != '0);
      end
   end

   // Next outstanding count; a simultaneous accept and response cancel out.
   always_comb begin
      cnt_nz = 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         cnt_d[i] = cnt_q[i];
         if (cnt_inc[i] && !cnt_dec[i]) begin
            cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
         end else if (cnt_dec[i] && !cnt_inc[i]) begin
            cnt_d[i] = cnt_q[i] - CNT_WIDTH'(1);
         end
         cnt_nz = cnt_nz | (cnt_q[i] != '0);
      end
   end

   // Outstanding counters; reset also forgets responses still in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   // Busy flag, one cycle behind slot/counter state.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= 1'b0;
      end else begin
         busy_q <= slot_valid_q || cnt_nz;
      end
   end

   assign request_read = request_read_q;
   assign request_data = request_data_q;
   assign busy         = busy_q;

`ifdef FDAM_RD_ARB_STATS_EN
   logic [NUM_REQ*32-1:0] issued_count_q;
   logic [31:0]           stall_count_q;

   // Accepted-word and stalled-slot statistics, wrapping on overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         issued_count_q <= '0;
         stall_count_q  <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
               issued_count_q[i*32 +: 32] <= issued_count_q[i*32 +: 32] + 32'd1;
            end
         end
         if (slot_valid_q && !available_read) begin
            stall_count_q <= stall_count_q + 32'd1;
         end
      end
   end

   assign issued_count = issued_count_q;
   assign stall_count  = stall_count_q;
`endif

endmodule
